// File: rtl/washer_plant_model_if.sv
// rtl/washer_plant_model_if.sv - controller/plant command and sensor bundle for washer_plant_model
interface washer_plant_model_if;
    logic       fill_valve;
    logic       drain_valve;
    logic       motor;
    logic       soap_dispenser;
    logic       clear_fault;
    logic [3:0] water_level;
    logic       level_full;
    logic       level_empty;
    logic [2:0] drum_speed;
    logic       soap_ok;
    logic       fault;
    logic [1:0] fault_code;

    modport master (
        output fill_valve, drain_valve, motor, soap_dispenser, clear_fault,
        input  water_level, level_full, level_empty, drum_speed, soap_ok, fault, fault_code
    );

    modport slave (
        input  fill_valve, drain_valve, motor, soap_dispenser, clear_fault,
        output water_level, level_full, level_empty, drum_speed, soap_ok, fault, fault_code
    );
endinterface

// File: rtl/washer_plant_model.sv
// rtl/washer_plant_model.sv - washing-machine tank/drum/soap plant model; optional leak via WM_PLANT_LEAK_EN
module washer_plant_model #(
    parameter int TICK_DIV   = 4,
    parameter int LEVEL_MAX  = 15,
    parameter int LEVEL_FULL = 12
) (
    input  logic                  clk,
    input  logic                  reset_n,
    washer_plant_model_if.slave   bus
);

    localparam int         CW        = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] PRE_LAST = CW'(TICK_DIV - 1);
    localparam logic [3:0] LVL_MAX   = 4'(LEVEL_MAX);
    localparam logic [3:0] LVL_FULL  = 4'(LEVEL_FULL);

    typedef enum logic [1:0] {
        FC_NONE     = 2'b00,
        FC_CONFLICT = 2'b01,
        FC_OVERFLOW = 2'b10,
        FC_SOAP_DRY = 2'b11
    } fault_code_t;

    logic [CW-1:0] pre_q;
    logic          tick;
    logic [3:0]    level_q, level_d;
    logic [2:0]    speed_q, speed_d;
    logic [1:0]    dose_q, dose_d;
    logic          soap_prev_q;
    logic          soap_rise;
    logic          soap_ok_q;
    logic          fault_q, fault_d;
    fault_code_t   code_q, code_d;
    logic          leak_wrap;
    logic          fill_only, drain_only;

    assign tick       = (pre_q == PRE_LAST);
    assign fill_only  = bus.fill_valve & ~bus.drain_valve;
    assign drain_only = bus.drain_valve & ~bus.fill_valve;
    assign soap_rise  = bus.soap_dispenser & ~soap_prev_q;

`ifdef WM_PLANT_LEAK_EN
    logic [5:0] leak_q;

    // Leak counter advances once per tick; its wrap marks a leak opportunity
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            leak_q <= 6'd0;
        else if (tick)
            leak_q <= leak_q + 6'd1;
    end

    assign leak_wrap = tick & (leak_q == 6'd63);
`else
    assign leak_wrap = 1'b0;
`endif

    // Free-running prescaler producing one tick every TICK_DIV clocks
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            pre_q <= '0;
        else if (tick)
            pre_q <= '0;
        else
            pre_q <= pre_q + 1'b1;
    end

    // Next-state for tank level, drum speed and soap dose
    always_comb begin
        level_d = level_q;
        speed_d = speed_q;
        dose_d  = dose_q;

        if (tick) begin
            if (fill_only && level_q < LVL_MAX)
                level_d = level_q + 4'd1;
            else if (drain_only && level_q != 4'd0)
                level_d = level_q - 4'd1;
            else if (leak_wrap && !bus.fill_valve && !bus.drain_valve && level_q != 4'd0)
                level_d = level_q - 4'd1;

            if (bus.motor && speed_q != 3'd7)
                speed_d = speed_q + 3'd1;
            else if (!bus.motor && speed_q != 3'd0)
                speed_d = speed_q - 3'd1;
        end

        // Emptying the tank washes the soap away; that wins over a new dose
        if (level_q != 4'd0 && level_d == 4'd0)
            dose_d = 2'd0;
        else if (soap_rise && dose_q != 2'd3)
            dose_d = dose_q + 2'd1;
    end

    // Fault latch: first fault sticks, a new fault beats a same-cycle clear
    always_comb begin
        logic        any_new;
        fault_code_t new_code;

        fault_d  = fault_q;
        code_d   = code_q;
        any_new  = 1'b1;
        new_code = FC_NONE;

        if (bus.fill_valve && bus.drain_valve)
            new_code = FC_CONFLICT;
        else if (tick && fill_only && level_q == LVL_MAX)
            new_code = FC_OVERFLOW;
        else if (soap_rise && level_q == 4'd0)
            new_code = FC_SOAP_DRY;
        else
            any_new = 1'b0;

        if (any_new && (!fault_q || bus.clear_fault)) begin
            fault_d = 1'b1;
            code_d  = new_code;
        end else if (bus.clear_fault) begin
            fault_d = 1'b0;
            code_d  = FC_NONE;
        end
    end

    // Plant state registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level_q     <= 4'd0;
            speed_q     <= 3'd0;
            dose_q      <= 2'd0;
            soap_prev_q <= 1'b0;
            soap_ok_q   <= 1'b0;
            fault_q     <= 1'b0;
            code_q      <= FC_NONE;
        end else begin
            level_q     <= level_d;
            speed_q     <= speed_d;
            dose_q      <= dose_d;
            soap_prev_q <= bus.soap_dispenser;
            soap_ok_q   <= (dose_q != 2'd0);
            fault_q     <= fault_d;
            code_q      <= code_d;
        end
    end

    assign bus.water_level = level_q;
    assign bus.level_full  = (level_q >= LVL_FULL);
    assign bus.level_empty = (level_q == 4'd0);
    assign bus.drum_speed  = speed_q;
    assign bus.soap_ok     = soap_ok_q;
    assign bus.fault       = fault_q;
    assign bus.fault_code  = code_q;

endmodule
